// File: rtl/gf2m_283_reducer.sv
// Iterative two-fold reducer modulo the NIST B-283 pentanomial x^283 + x^12 + x^7 + x^5 + 1.
// Takes a 2M-bit carry-less product and delivers the canonical M-bit field element.
module gf2m_283_reducer #(
    parameter int M  = 283,
    parameter int K1 = 12,
    parameter int K2 = 7,
    parameter int K3 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             busy
);

    // Two folds are only enough when the taps stay below M/2.
    generate
        if (!(M > K1 && K1 > K2 && K2 > K3 && K3 > 0 && K1 < M / 2)) begin : g_illegal_taps
            $error("gf2m_283_reducer: illegal pentanomial parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, HOLD} state_t;

    state_t             state;
    logic [2*M-1:0]     acc;
    logic [M+K1-1:0]    h_ext;
    logic [M+K1-1:0]    fold1;
    logic [M-1:0]       h2_ext;
    logic [M-1:0]       fold2;

    always_comb begin
        h_ext  = {{K1{1'b0}}, acc[2*M-1:M]};
        fold1  = {{K1{1'b0}}, acc[M-1:0]} ^ h_ext ^ (h_ext << K3) ^ (h_ext << K2) ^ (h_ext << K1);
        // After the first fold only K1 bits remain above x^(M-1).
        h2_ext = {{(M-K1){1'b0}}, acc[M+K1-1:M]};
        fold2  = acc[M-1:0] ^ h2_ext ^ (h2_ext << K3) ^ (h2_ext << K2) ^ (h2_ext << K1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= in_data;
                        state    <= FOLD1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FOLD1: begin
                    acc   <= {{(M-K1){1'b0}}, fold1};
                    state <= FOLD2;
                end
                FOLD2: begin
                    out_data  <= fold2;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_283_reducer.sv
// Self-checking bench for gf2m_283_reducer: directed vector table, handshake corner cases
// and a random product stream checked against a bit-serial long-division model.
module tb_gf2m_283_reducer;

    localparam int M = 283;
    localparam int W = 2 * M;
    localparam int NREG = 200;
    localparam logic [M:0] F_POLY = (284'(1) << 283) | 284'h10A1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit regress_on = 0;
    logic [M-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gf2m_283_reducer #(.M(M), .K1(12), .K2(7), .K3(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] din;
        logic [M-1:0] dout;
    } vec_t;

    vec_t vecs[9];

    // Reference reduction by schoolbook long division, one leading bit at a time.
    function automatic logic [M-1:0] refReduce(input logic [W-1:0] p);
        logic [W-1:0] r;
        r = p;
        for (int i = W - 1; i >= M; i--) begin
            if (r[i]) r = r ^ (W'(F_POLY) << (i - M));
        end
        return r[M-1:0];
    endfunction

    function automatic logic [W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ (W'(a) << i);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] randElem();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[M-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, " in_ready before accept"}, W'(in_ready), W'(1'b1));
    endtask

    // Push one product through with out_ready low until the result appears.
    task automatic applyStimulus(input logic [W-1:0] d, input logic [M-1:0] expected, input string name);
        waitReady(name);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        checkOutput({name, " busy after accept"}, W'(busy), W'(1'b1));
        @(posedge clk); #1;
        checkOutput({name, " out_valid early"}, W'(out_valid), W'(1'b0));
        @(posedge clk); #1;
        checkOutput({name, " out_valid at k+3"}, W'(out_valid), W'(1'b1));
        checkOutput({name, " out_data"}, W'(out_data), W'(expected));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, " in_ready after release"}, W'(in_ready), W'(1'b1));
        checkOutput({name, " out_valid after release"}, W'(out_valid), W'(1'b0));
    endtask

    // Scoreboard for the streaming regression.
    always @(negedge clk) begin
        if (regress_on && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL regress unexpected output: got %h expected none", out_data);
            end else begin
                checkOutput("regress out_data", W'(out_data), W'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] prods[NREG];
        logic [M-1:0] held;
        bit acc_now;
        int idx, cyc, last_acc;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", W'(in_ready), W'(1'b1));
        checkOutput("reset out_valid", W'(out_valid), W'(1'b0));
        checkOutput("reset busy", W'(busy), W'(1'b0));
        checkOutput("reset out_data", W'(out_data), '0);
        rst = 1'b0;

        vecs[0].din  = W'(1) << 565;
        vecs[0].dout = (M'(1) << 282) | (M'(1) << 23) | (M'(1) << 13) | (M'(1) << 11)
                     | (M'(1) << 9) | (M'(1) << 6) | (M'(1) << 4);
        vecs[1].din  = W'(1) << 283;
        vecs[1].dout = M'(13'h10A1);
        vecs[2].din  = '0;
        vecs[2].dout = '0;
        vecs[3].dout = randElem();
        vecs[3].din  = W'(vecs[3].dout);
        vecs[4].din  = W'(1) << 284;
        vecs[4].dout = M'(14'h2142);
        vecs[5].din  = W'(1) << 553;
        vecs[5].dout = (M'(1) << 282) | (M'(1) << 277) | (M'(1) << 275) | (M'(1) << 270);
        vecs[6].din  = W'(1) << 554;
        vecs[6].dout = (M'(1) << 278) | (M'(1) << 276) | (M'(1) << 271) | M'(13'h10A1);
        vecs[7].din  = W'(F_POLY);
        vecs[7].dout = '0;
        vecs[8].din  = W'({M{1'b1}});
        vecs[8].dout = {M{1'b1}};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
        end

        // Backpressure: result must stay frozen while new inputs are offered.
        waitReady("backpressure");
        in_data  = vecs[0].din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        held = vecs[0].dout;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {randElem(), randElem()};
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d out_valid", i), W'(out_valid), W'(1'b1));
            checkOutput($sformatf("bp%0d out_data", i), W'(out_data), W'(held));
            checkOutput($sformatf("bp%0d in_ready", i), W'(in_ready), W'(1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp release in_ready", W'(in_ready), W'(1'b1));
        checkOutput("bp release out_valid", W'(out_valid), W'(1'b0));
        checkOutput("bp release busy", W'(busy), W'(1'b0));
        checkOutput("bp retained out_data", W'(out_data), W'(held));

        // Reset while in FOLD1 abandons the operation.
        in_data  = vecs[1].din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("midreset busy in FOLD1", W'(busy), W'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midreset in_ready", W'(in_ready), W'(1'b1));
        checkOutput("midreset out_valid", W'(out_valid), W'(1'b0));
        checkOutput("midreset busy", W'(busy), W'(1'b0));
        checkOutput("midreset out_data", W'(out_data), '0);
        applyStimulus(vecs[6].din, vecs[6].dout, "post-reset");

        // Streaming regression with out_ready tied high.
        for (int i = 0; i < NREG; i++) prods[i] = clmul(randElem(), randElem());
        regress_on = 1'b1;
        out_ready  = 1'b1;
        idx = 0;
        cyc = 0;
        last_acc = 0;
        in_data  = prods[0];
        in_valid = 1'b1;
        while (idx < NREG && cyc < NREG * 8) begin
            @(negedge clk);
            acc_now = in_ready;
            @(posedge clk);
            if (acc_now) begin
                exp_q.push_back(refReduce(prods[idx]));
                if (idx > 0) checkOutput("regress spacing", W'(cyc - last_acc), W'(4));
                last_acc = cyc;
                idx++;
            end
            #1;
            if (idx < NREG) in_data = prods[idx];
            else in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("regress all accepted", W'(idx), W'(NREG));
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("regress drained", W'(exp_q.size()), '0);
        regress_on = 1'b0;
        out_ready  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
